// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared constants for the load/store unit: memory operation
//               codes, write-enable levels, FSM state encodings and small
//               helpers for access classification and address alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  // Memory operation codes delivered by the execute stage
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [31:0] ZERO          = 32'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  // Low address bits rounded down to the natural alignment of the access
  function automatic logic [1:0] align_lo(input logic [3:0] op, input logic [1:0] lo);
    logic [1:0] res;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: res = {lo[1], 1'b0};
      MEM_LW, MEM_SW:          res = 2'b00;
      default:                 res = lo;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    return align_lo(op, lo) != lo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load formatter. Picks the addressed byte or
//               halfword out of the bus read word and sign/zero-extends it.
// Ports       : op      - memory operation code
//               addr_lo - address bits [1:0] (already aligned)
//               rdata   - raw 32-bit bus read data
//               load_data - extended 32-bit writeback value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'd0;
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (op)
      MEM_LB:  load_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: load_data = {24'd0, w_byte};
      MEM_LH:  load_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: load_data = {16'd0, w_half};
      default: load_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Load/store stage. Accepts one operation at a time from
//               execute, runs a request/grant/response bus transaction for
//               memory ops and returns a registered one-cycle writeback.
//               Non-memory ops pass straight through with one-cycle latency.
//               A WAIT-state counter aborts a transaction that never gets a
//               response and flags it on bus_err_out.
// Macro       : MISALIGN_TRAP_EN - when defined, misaligned LH/LHU/SH/LW/SW
//               are trapped (misalign_out) instead of being force-aligned.
// Ports       : clk_in, reset_in (async, active-high)
//               valid_in/ready_out, mem_op_in, mem_addr_in, mem_data_in,
//               mem_we_in, reg_we_in/reg_waddr_in/reg_wdata_in - upstream
//               bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out,
//               bus_be_out, bus_gnt_in, bus_rvalid_in, bus_rdata_in - data bus
//               valid_out, reg_we_out, reg_waddr_out, reg_wdata_out,
//               bus_err_out, [misalign_out] - writeback
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [3:0]  mem_op_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_data_in,
  input  logic        mem_we_in,
  input  logic        reg_we_in,
  input  logic [4:0]  reg_waddr_in,
  input  logic [31:0] reg_wdata_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_be_out,
  input  logic        bus_gnt_in,
  input  logic        bus_rvalid_in,
  input  logic [31:0] bus_rdata_in,
  output logic        valid_out,
  output logic        reg_we_out,
  output logic [4:0]  reg_waddr_out,
  output logic [31:0] reg_wdata_out,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic        bus_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_trap;
  logic [1:0]       w_lo_in;
  logic [31:0]      w_load;

  assign w_accept = valid_in && (r_state == ST_IDLE);

`ifdef MISALIGN_TRAP_EN
  assign w_lo_in = mem_addr_in[1:0];
  assign w_trap  = (mem_op_in != MEM_NOP) && is_misaligned(mem_op_in, mem_addr_in[1:0]);
`else
  // Misaligned accesses are silently rounded down to their natural alignment
  assign w_lo_in = align_lo(mem_op_in, mem_addr_in[1:0]);
  assign w_trap  = 1'b0;
`endif

  mem_load_align u_load_align (
    .op        (r_op),
    .addr_lo   (r_addr[1:0]),
    .rdata     (bus_rdata_in),
    .load_data (w_load)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state       <= ST_IDLE;
      r_op          <= MEM_NOP;
      r_addr        <= ZERO;
      r_data        <= ZERO;
      r_we          <= WRITE_DISABLE;
      r_waddr       <= 5'd0;
      r_cnt         <= '0;
      valid_out     <= 1'b0;
      reg_we_out    <= WRITE_DISABLE;
      reg_waddr_out <= 5'd0;
      reg_wdata_out <= ZERO;
      bus_err_out   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_out  <= 1'b0;
`endif
    end else begin
      // Writeback strobes are single-cycle pulses
      valid_out   <= 1'b0;
      reg_we_out  <= WRITE_DISABLE;
      bus_err_out <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_out <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (mem_op_in == MEM_NOP) begin
              valid_out     <= 1'b1;
              reg_we_out    <= reg_we_in;
              reg_waddr_out <= reg_waddr_in;
              reg_wdata_out <= reg_wdata_in;
            end else if (w_trap) begin
              valid_out     <= 1'b1;
              reg_waddr_out <= reg_waddr_in;
              reg_wdata_out <= ZERO;
`ifdef MISALIGN_TRAP_EN
              misalign_out  <= 1'b1;
`endif
            end else begin
              r_op    <= mem_op_in;
              r_addr  <= {mem_addr_in[31:2], w_lo_in};
              r_data  <= mem_data_in;
              r_we    <= mem_we_in;
              r_waddr <= reg_waddr_in;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt_in) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_in) begin
            valid_out     <= 1'b1;
            reg_we_out    <= is_load(r_op);
            reg_waddr_out <= r_waddr;
            reg_wdata_out <= is_load(r_op) ? w_load : ZERO;
            r_state       <= ST_IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            valid_out     <= 1'b1;
            bus_err_out   <= 1'b1;
            reg_waddr_out <= r_waddr;
            reg_wdata_out <= ZERO;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_out    = (r_state == ST_IDLE);
  assign bus_req_out  = (r_state == ST_REQ);
  assign bus_we_out   = r_we;
  assign bus_addr_out = {r_addr[31:2], 2'b00};

  always_comb begin
    bus_be_out    = 4'b0000;
    bus_wdata_out = ZERO;
    case (r_op)
      MEM_SB: begin
        bus_be_out    = 4'b0001 << r_addr[1:0];
        bus_wdata_out = {4{r_data[7:0]}};
      end
      MEM_SH: begin
        bus_be_out    = 4'b0011 << {r_addr[1], 1'b0};
        bus_wdata_out = {2{r_data[15:0]}};
      end
      MEM_SW: begin
        bus_be_out    = 4'b1111;
        bus_wdata_out = r_data;
      end
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: bus_be_out = 4'b1111;
      default: bus_be_out = 4'b0000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. Table of transactions,
//               expected writebacks queued at issue and compared when
//               valid_out fires, plus hand sequences for reset and traps.
// Macro       : MISALIGN_TRAP_EN - selects trap vs force-align vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out;
  logic [3:0]  mem_op_in;
  logic [31:0] mem_addr_in, mem_data_in;
  logic        mem_we_in, reg_we_in;
  logic [4:0]  reg_waddr_in;
  logic [31:0] reg_wdata_in;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_gnt_in, bus_rvalid_in;
  logic [31:0] bus_rdata_in;
  logic        valid_out, reg_we_out;
  logic [4:0]  reg_waddr_out;
  logic [31:0] reg_wdata_out;
  logic        bus_err_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_out;
`endif

  mem_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_in        (clk),
    .reset_in      (rst),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .mem_op_in     (mem_op_in),
    .mem_addr_in   (mem_addr_in),
    .mem_data_in   (mem_data_in),
    .mem_we_in     (mem_we_in),
    .reg_we_in     (reg_we_in),
    .reg_waddr_in  (reg_waddr_in),
    .reg_wdata_in  (reg_wdata_in),
    .bus_req_out   (bus_req_out),
    .bus_we_out    (bus_we_out),
    .bus_addr_out  (bus_addr_out),
    .bus_wdata_out (bus_wdata_out),
    .bus_be_out    (bus_be_out),
    .bus_gnt_in    (bus_gnt_in),
    .bus_rvalid_in (bus_rvalid_in),
    .bus_rdata_in  (bus_rdata_in),
    .valid_out     (valid_out),
    .reg_we_out    (reg_we_out),
    .reg_waddr_out (reg_waddr_out),
    .reg_wdata_out (reg_wdata_out),
`ifdef MISALIGN_TRAP_EN
    .misalign_out  (misalign_out),
`endif
    .bus_err_out   (bus_err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        rwe;
    logic [4:0]  waddr;
    logic [31:0] rwdata;
    logic [31:0] rdata;
    int          gd;      // cycles grant is held low in REQ
    int          rd;      // cycles before rvalid in WAIT; -1 = never
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] baddr;
    logic        xwe;
    logic [31:0] xwdata;
    logic        xerr;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input vec_t v);
    vt.push_back(v);
  endtask

  // Writeback monitor: every valid_out must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: valid_out=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("reg_we_out", reg_we_out, e.we);
        check("reg_waddr_out", reg_waddr_out, e.waddr);
        if (e.we) check("reg_wdata_out", reg_wdata_out, e.wdata);
        check("bus_err_out", bus_err_out, e.err);
`ifdef MISALIGN_TRAP_EN
        check("misalign_out", misalign_out, e.mis);
`endif
      end
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 6 && sb.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: writeback missing, %0d outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input vec_t v);
    int   k;
    int   e;
    exp_t x;
    @(negedge clk);
    check("ready_idle", ready_out, 1'b1);
    mem_op_in    = v.op;
    mem_addr_in  = v.addr;
    mem_data_in  = v.data;
    mem_we_in    = v.we;
    reg_we_in    = v.rwe;
    reg_waddr_in = v.waddr;
    reg_wdata_in = v.rwdata;
    valid_in     = 1'b1;
    k = cyc;
    if (v.op == MEM_NOP) e = k + 1;
    else e = k + 2 + v.gd + ((v.rd >= 0) ? v.rd + 1 : TIMEOUT);
    x = '{e, v.xwe, v.waddr, v.xwdata, v.xerr, 1'b0};
    sb.push_back(x);
    @(negedge clk);
    if (v.op == MEM_NOP) begin
      valid_in = 1'b0;
      check("nop_no_req", bus_req_out, 1'b0);
    end else begin
      // Busy: new requests and changed inputs must be ignored
      valid_in     = 1'b1;
      mem_op_in    = MEM_NOP;
      mem_addr_in  = ~v.addr;
      mem_data_in  = ~v.data;
      reg_waddr_in = ~v.waddr;
      reg_wdata_in = 32'hBAD0_BAD0;
      for (int i = 0; i <= v.gd; i++) begin
        check("bus_req_out", bus_req_out, 1'b1);
        check("bus_be_out", bus_be_out, v.be);
        check("bus_addr_out", bus_addr_out, v.baddr);
        check("bus_we_out", bus_we_out, v.we);
        if (v.we) check("bus_wdata_out", bus_wdata_out, v.bwdata);
        if (i == v.gd) bus_gnt_in = 1'b1;
        @(negedge clk);
      end
      bus_gnt_in = 1'b0;
      check("req_drop_in_wait", bus_req_out, 1'b0);
      if (v.rd >= 0) begin
        bus_rdata_in = ~v.rdata;
        repeat (v.rd) @(negedge clk);
        bus_rvalid_in = 1'b1;
        bus_rdata_in  = v.rdata;
        valid_in      = 1'b0;
        @(negedge clk);
        bus_rvalid_in = 1'b0;
        bus_rdata_in  = ~v.rdata;
      end else begin
        repeat (TIMEOUT) @(negedge clk);
        valid_in = 1'b0;
      end
    end
    wait_drain("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    rst = 1'b1;
    valid_in = 1'b0; mem_op_in = MEM_NOP; mem_addr_in = '0; mem_data_in = '0;
    mem_we_in = 1'b0; reg_we_in = 1'b0; reg_waddr_in = '0; reg_wdata_in = '0;
    bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0; bus_rdata_in = '0;

    //   op       addr          data          we    rwe   wa     rwdata        rdata         gd rd  be       bwdata        baddr         xwe   xwdata        xerr
    add('{MEM_LB,  32'h0000_1003, 32'h0,        1'b0, 1'b0, 5'd1,  32'h0,        32'h80FF_FFFF, 0, 0, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'hFFFF_FF80, 1'b0});
    add('{MEM_LBU, 32'h0000_1002, 32'h0,        1'b0, 1'b0, 5'd2,  32'h0,        32'h12F4_5678, 0, 0, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'h0000_00F4, 1'b0});
    add('{MEM_LB,  32'h0000_1002, 32'h0,        1'b0, 1'b0, 5'd3,  32'h0,        32'h12F4_5678, 1, 1, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'hFFFF_FFF4, 1'b0});
    add('{MEM_LH,  32'h0000_1002, 32'h0,        1'b0, 1'b0, 5'd4,  32'h0,        32'h8001_1234, 0, 0, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'hFFFF_8001, 1'b0});
    add('{MEM_LHU, 32'h0000_1000, 32'h0,        1'b0, 1'b0, 5'd5,  32'h0,        32'h0000_9ABC, 0, 0, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'h0000_9ABC, 1'b0});
    add('{MEM_LW,  32'h0000_1004, 32'h0,        1'b0, 1'b0, 5'd6,  32'h0,        32'hDEAD_BEEF, 2, 3, 4'b1111, 32'h0,        32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 1'b0});
    add('{MEM_SB,  32'h0000_2001, 32'h1234_56A5, 1'b1, 1'b0, 5'd8,  32'h0,        32'h0,        0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_2000, 1'b0, 32'h0,        1'b0});
    add('{MEM_SB,  32'h0000_2003, 32'h0000_007E, 1'b1, 1'b0, 5'd9,  32'h0,        32'h0,        1, 0, 4'b1000, 32'h7E7E_7E7E, 32'h0000_2000, 1'b0, 32'h0,        1'b0});
    add('{MEM_SH,  32'h0000_2002, 32'h1234_ABCD, 1'b1, 1'b0, 5'd10, 32'h0,        32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000, 1'b0, 32'h0,        1'b0});
    add('{MEM_SW,  32'h0000_2008, 32'hCAFE_F00D, 1'b1, 1'b0, 5'd11, 32'h0,        32'h0,        0, 2, 4'b1111, 32'hCAFE_F00D, 32'h0000_2008, 1'b0, 32'h0,        1'b0});
    add('{MEM_NOP, 32'h0,        32'h0,        1'b0, 1'b1, 5'd7,  32'h0000_0055, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0000_0055, 1'b0});
    add('{MEM_NOP, 32'h0,        32'h0,        1'b0, 1'b0, 5'd12, 32'h0000_1111, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0});
    add('{MEM_LW,  32'h0000_1000, 32'h0,        1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        5, -1, 4'b1111, 32'h0,       32'h0000_1000, 1'b0, 32'h0,        1'b1});
    add('{MEM_LW,  32'h0000_1010, 32'h0,        1'b0, 1'b0, 5'd14, 32'h0,        32'h0123_4567, 0, 0, 4'b1111, 32'h0,        32'h0000_1010, 1'b1, 32'h0123_4567, 1'b0});
`ifndef MISALIGN_TRAP_EN
    // Misaligned accesses rounded down to natural alignment
    add('{MEM_LH,  32'h0000_1003, 32'h0,        1'b0, 1'b0, 5'd15, 32'h0,        32'h7FFF_0000, 0, 0, 4'b1111, 32'h0,        32'h0000_1000, 1'b1, 32'h0000_7FFF, 1'b0});
    add('{MEM_SW,  32'h0000_2005, 32'h0BAD_F00D, 1'b1, 1'b0, 5'd16, 32'h0,        32'h0,        0, 0, 4'b1111, 32'h0BAD_F00D, 32'h0000_2004, 1'b0, 32'h0,        1'b0});
    add('{MEM_SH,  32'h0000_2001, 32'hFFFF_1111, 1'b1, 1'b0, 5'd17, 32'h0,        32'h0,        0, 0, 4'b0011, 32'h1111_1111, 32'h0000_2000, 1'b0, 32'h0,        1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ready_out, 1'b1);
    check("rst_valid", valid_out, 1'b0);
    check("rst_req", bus_req_out, 1'b0);
    check("rst_be", bus_be_out, 4'b0000);
    check("rst_addr", bus_addr_out, 32'h0);
    check("rst_err", bus_err_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", ready_out, 1'b1);

    // Stray grant/response while idle must not start anything
    bus_gnt_in = 1'b1; bus_rvalid_in = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_gnt_ignored", ready_out, 1'b1);
    check("idle_rvalid_no_req", bus_req_out, 1'b0);
    bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0;

    foreach (vt[i]) run(vt[i]);

    // Reset during WAIT aborts without writeback; late rvalid is ignored
    @(negedge clk);
    mem_op_in = MEM_LW; mem_addr_in = 32'h4000; mem_we_in = 1'b0; reg_waddr_in = 5'd20;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; bus_gnt_in = 1'b1;
    @(negedge clk);
    bus_gnt_in = 1'b0;
    check("abort_in_wait", ready_out, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_req", bus_req_out, 1'b0);
    check("abort_valid", valid_out, 1'b0);
    check("abort_ready", ready_out, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_release", ready_out, 1'b1);
    bus_rvalid_in = 1'b1; bus_rdata_in = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid_in = 1'b0;
    check("late_rvalid_valid", valid_out, 1'b0);
    check("late_rvalid_req", bus_req_out, 1'b0);

    // Reset during REQ drops the request immediately
    mem_op_in = MEM_SW; mem_addr_in = 32'h5000; mem_we_in = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("req_before_reset", bus_req_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("req_after_reset", bus_req_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("req_reset_settled", bus_req_out, 1'b0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word access traps without touching the bus
    @(negedge clk);
    mem_op_in = MEM_LW; mem_addr_in = 32'h3001; mem_we_in = 1'b0; reg_waddr_in = 5'd21;
    valid_in = 1'b1;
    x = '{cyc + 1, 1'b0, 5'd21, 32'h0, 1'b0, 1'b1};
    sb.push_back(x);
    @(negedge clk);
    valid_in = 1'b0;
    check("trap_no_req", bus_req_out, 1'b0);
    check("trap_ready", ready_out, 1'b1);
    wait_drain("trap_drain");
`else
    x = '{0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles waiting for bus_rvalid_in before abort.
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 reset_in  input  1  asynchronous, active-high reset.
REQ-004 valid_in / ready_out  input / output  1 / 1  upstream handshake; transfer when both high.
REQ-005 mem_op_in  input  4  MEM_NOP/LB/LBU/LH/LHU/LW/SB/SH/SW code from execute.
REQ-006 mem_addr_in, mem_data_in  input  32 each  effective address, store data.
REQ-007 mem_we_in  input  1  store flag.
REQ-008 reg_we_in, reg_waddr_in, reg_wdata_in  input  1/5/32  writeback from execute, passed through.
REQ-009 bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_be_out  output  1/1/32/32/4  data-bus request.
REQ-010 bus_gnt_in, bus_rvalid_in, bus_rdata_in  input  1/1/32  grant, response strobe, read data.
REQ-011 valid_out, reg_we_out, reg_waddr_out, reg_wdata_out  output  1/1/5/32  registered writeback, one-cycle pulse.
REQ-012 bus_err_out  output  1  timeout pulse, coincident with valid_out.

Function
REQ-013 FSM states IDLE, REQ, WAIT; ready_out = (state==IDLE).
REQ-014 IDLE, accept with mem_op_in==MEM_NOP: next cycle valid_out=1, reg_* = reg_*_in; stay IDLE (1-cycle latency).
REQ-015 IDLE, accept with memory op: latch op, addr, data, reg_waddr_in; go REQ.
REQ-016 REQ: bus_req_out=1 with stable addr/we/be/wdata until bus_gnt_in; on gnt go WAIT.
REQ-017 WAIT: on bus_rvalid_in, next cycle valid_out=1, return IDLE; stores ack via rvalid, reg_we_out=0.
REQ-018 bus_addr_out = latched addr with bits[1:0] cleared; bus_we_out = latched mem_we.
REQ-019 bus_be_out: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111.
REQ-020 bus_wdata_out: SB {4{data[7:0]}}; SH {2{data[15:0]}}; SW data.
REQ-021 Loads: select byte/halfword of bus_rdata_in by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; reg_we_out=1.
REQ-022 Minimum memory-op latency: accept->valid_out = 3 cycles (gnt and rvalid each first cycle offered).
REQ-023 bus_rvalid_in outside WAIT, bus_gnt_in outside REQ: ignored.
REQ-024 Timeout counter clears entering WAIT; at TIMEOUT_CYCLES without rvalid: valid_out=1, bus_err_out=1, reg_we_out=0, IDLE.
REQ-025 valid_in ignored while ready_out=0; no upstream buffering.

Reset
REQ-026 reset_in forces IDLE, counter 0, all outputs 0 (ready_out=1 after release), including mid-transaction; aborted op produces no valid_out.

Configuration
REQ-027 MISALIGN_TRAP_EN defined: LH/LHU/SH addr[0]!=0 or LW/SW addr[1:0]!=0 issues no bus request; next cycle valid_out=1, misalign_out=1, reg_we_out=0.
REQ-028 MISALIGN_TRAP_EN undefined: no misalign_out port; low address bits forced to access alignment before REQ-019/021.

Structure
REQ-029 Mem op codes, MEM_NOP, ZERO, WRITE_ENABLE/DISABLE from defines.v; FSM state encodings added there.
REQ-030 Sub-module mem_load_align: combinational op+addr[1:0]+rdata -> 32-bit extended load value.

Verification
REQ-031 LB addr 0x1003, rdata 0x80FF_FFFF, gnt/rvalid immediate -> valid_out 3 cycles after accept, reg_wdata_out 0xFFFF_FF80.
REQ-032 SH addr 0x2002, data 0x1234_ABCD -> bus_be_out 4'b1100, bus_wdata_out 0xABCD_ABCD, bus_addr_out 0x2000, reg_we_out 0.
REQ-033 MEM_NOP, reg_wdata_in 0x55, waddr 7 -> next cycle valid_out=1, reg_wdata_out 0x55, reg_waddr_out 7, no bus_req_out.
REQ-034 LW, gnt held 0 for 5 cycles then 1, rvalid never -> bus_req_out stays 1 five cycles; bus_err_out after 16 WAIT cycles.
REQ-035 reset_in asserted in WAIT -> bus_req_out/valid_out 0 immediately, ready_out 1 after release, late rvalid ignored.
REQ-036 MISALIGN_TRAP_EN, LW addr 0x3001 -> misalign_out and valid_out next cycle, no bus_req_out.
